data_mem_port: RTL and testbench

Data-memory access unit driven by the core's memory control codes: the store-width code (`mem_write`, same encoding the control unit drives on MemWrite) and the load-select code (`load_sel`, same encoding as MemtoReg). It executes SB/SH/SW and LB/LH/LW against a word-wide, single-port, handshaked memory that has no byte enables. Sub-word stores are done as read-modify-write. It sits between the datapath and the data RAM, and `busy` stalls the core.

---
 rtl/data_mem_port.sv | 212 +++++++++++++++++++++
 tb/tb_data_mem_port.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_port.sv
// Data-memory access unit: SB/SH/SW and LB/LH/LW against a word-wide handshaked RAM,
// sub-word stores by read-modify-write. Optional misalignment trap: DMEM_MISALIGN_TRAP_EN.
module data_mem_port #(
   parameter int MEM_AW = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [1:0]        mem_write,
   input  logic [2:0]        load_sel,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata,
`ifdef DMEM_MISALIGN_TRAP_EN
   output logic              misalign,
`endif
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t              state_q;
   logic [1:0]          mw_q;
   logic [2:0]          ls_q;
   logic [1:0]          lane_q;
   logic [15:0]         wd_q;
   logic                busy_q;
   logic                done_q;
   logic [31:0]         rdata_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [MEM_AW-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic                misalign_q;
`endif
   logic                unused_addr_s;

   function automatic logic is_load(input logic [2:0] sel);
      logic r;
      case (sel)
         3'b100, 3'b101, 3'b110: r = 1'b1;
         default:                r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [15:0] new_d,
                                              input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] w;
      w = old_w;
      case (size)
         2'b01:   w[{lane, 3'b000} +: 8]     = new_d[7:0];
         2'b10:   w[{lane[1], 4'b0000} +: 16] = new_d;
         default: w = old_w;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [2:0] sel,
                                                input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (sel)
         3'b100:  r = {{24{b[7]}}, b};
         3'b101:  r = {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [1:0] mw, input logic [2:0] sel,
                                          input logic [1:0] lane);
      logic m;
      case (mw)
         2'b01: m = 1'b0;
         2'b10: m = lane[0];
         2'b11: m = (lane != 2'b00);
         default: begin
            case (sel)
               3'b101:  m = lane[0];
               3'b110:  m = (lane != 2'b00);
               default: m = 1'b0;
            endcase
         end
      endcase
      return m;
   endfunction
`endif

   // Access sequencer: all outputs are registered here
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mw_q        <= 2'b00;
         ls_q        <= 3'b000;
         lane_q      <= 2'b00;
         wd_q        <= 16'h0000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rdata_q     <= 32'h0000_0000;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'h0000_0000;
`ifdef DMEM_MISALIGN_TRAP_EN
         misalign_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  mw_q       <= mem_write;
                  ls_q       <= load_sel;
                  lane_q     <= addr[1:0];
                  wd_q       <= wdata[15:0];
                  busy_q     <= 1'b1;
                  mem_addr_q <= addr[MEM_AW+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
                  if (is_misaligned(mem_write, load_sel, addr[1:0])) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     misalign_q <= 1'b1;
                  end else
`endif
                  if (mem_write == 2'b11) begin
                     state_q     <= WRITE;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b1;
                     mem_wdata_q <= wdata;
                  end else if ((mem_write != 2'b00) || is_load(load_sel)) begin
                     state_q   <= READ;
                     mem_req_q <= 1'b1;
                     mem_we_q  <= 1'b0;
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            READ: begin
               if (mem_ack) begin
                  if (mw_q != 2'b00) begin
                     // Sub-word store: merge into the fetched word, keep the request up
                     mem_wdata_q <= merge_word(mem_rdata, wd_q, mw_q, lane_q);
                     mem_we_q    <= 1'b1;
                     state_q     <= WRITE;
                  end else begin
                     rdata_q   <= extract_load(mem_rdata, ls_q, lane_q);
                     mem_req_q <= 1'b0;
                     state_q   <= DONE;
                     done_q    <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  state_q   <= DONE;
                  done_q    <= 1'b1;
               end
            end
            DONE: begin
               state_q    <= IDLE;
               done_q     <= 1'b0;
               busy_q     <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
               misalign_q <= 1'b0;
`endif
            end
            default: begin
               state_q   <= IDLE;
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               mem_req_q <= 1'b0;
               mem_we_q  <= 1'b0;
            end
         endcase
      end
   end

   assign unused_addr_s = ^addr[31:MEM_AW+2];

   assign busy      = busy_q;
   assign done      = done_q;
   assign rdata     = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_data_mem_port.sv
// Self-checking bench for data_mem_port: bench-side RAM responder with wait states,
// byte-level reference model, directed test-plan cases and randomized traffic.
module tb_data_mem_port;
   localparam int AW = 10;

   logic              clk = 1'b0;
   logic              reset;
   logic              req;
   logic [1:0]        mem_write;
   logic [2:0]        load_sel;
   logic [31:0]       addr;
   logic [31:0]       wdata;
   logic              busy;
   logic              done;
   logic [31:0]       rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic              misalign;
`endif
   logic              mem_req;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_ack = 1'b0;
   logic [31:0]       mem_rdata = 32'h0000_0000;

   int checks = 0;
   int errors = 0;

   bit [31:0]     tbmem [0:(1<<AW)-1];
   int            ack_delay = 0;
   bit            ack_noise = 1'b0;
   int            wait_cnt = 0;
   bit            pre_en = 1'b0;
   logic [AW-1:0] pre_addr;
   logic [31:0]   pre_data;
   int            rd_cnt = 0;
   int            wr_cnt = 0;
   int            unstable_cnt = 0;
   bit            hold_v = 1'b0;
   logic [AW+32:0] hold;
   logic [31:0]   rdata_m;

   always #5 clk = ~clk;

   data_mem_port #(.MEM_AW(AW)) dut (
      .clk(clk), .reset(reset), .req(req), .mem_write(mem_write), .load_sel(load_sel),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
`ifdef DMEM_MISALIGN_TRAP_EN
      .misalign(misalign),
`endif
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   // RAM responder: ack after ack_delay wait cycles per access, optional stray acks when idle
   always @(negedge clk) begin
      if (mem_req) begin
         if (wait_cnt >= ack_delay) begin
            mem_ack   <= 1'b1;
            mem_rdata <= tbmem[mem_addr];
            wait_cnt  <= 0;
         end else begin
            mem_ack   <= 1'b0;
            mem_rdata <= $urandom;
            wait_cnt  <= wait_cnt + 1;
         end
      end else begin
         mem_ack   <= ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
         mem_rdata <= $urandom;
         wait_cnt  <= 0;
      end
   end

   // RAM array, transfer counters and request-stability monitor
   always @(posedge clk) begin
      if (pre_en) tbmem[pre_addr] <= pre_data;
      else if (mem_req && mem_ack && mem_we) tbmem[mem_addr] <= mem_wdata;
      if (mem_req && mem_ack) begin
         if (mem_we) wr_cnt <= wr_cnt + 1;
         else        rd_cnt <= rd_cnt + 1;
      end
      if (mem_req) begin
         if (hold_v && (hold !== {mem_we, mem_addr, mem_wdata})) unstable_cnt <= unstable_cnt + 1;
         hold   <= {mem_we, mem_addr, mem_wdata};
         hold_v <= !mem_ack;
      end else begin
         hold_v <= 1'b0;
      end
   end

   task automatic preload(input logic [AW-1:0] w, input logic [31:0] d);
      pre_addr = w;
      pre_data = d;
      pre_en   = 1'b1;
      @(posedge clk); #1;
      pre_en   = 1'b0;
   endtask

   // Byte-level reference: memory word after, transfers, latency, misalign, load value
   task automatic model(input logic [1:0] mw, input logic [2:0] ls, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] old, input int dly,
                        output logic [31:0] new_w, output int n_rd, output int n_wr,
                        output int lat, output bit mis, output bit is_ld, output logic [31:0] ld_val);
      logic [7:0] b [4];
      int lane, h, v;
      for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
      lane   = int'(a[1:0]);
      h      = a[1] ? 2 : 0;
      is_ld  = (mw == 2'b00) && (ls == 3'b100 || ls == 3'b101 || ls == 3'b110);
      mis    = 1'b0;
      n_rd   = 0;
      n_wr   = 0;
      ld_val = 32'h0000_0000;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (mw == 2'b10 || (mw == 2'b00 && ls == 3'b101)) mis = a[0];
      if (mw == 2'b11 || (mw == 2'b00 && ls == 3'b110)) mis = (a[1:0] != 2'b00);
`endif
      if (mis) begin
         is_ld = 1'b0;
      end else if (mw == 2'b11) begin
         for (int i = 0; i < 4; i++) b[i] = wd[8*i +: 8];
         n_wr = 1;
      end else if (mw == 2'b01) begin
         b[lane] = wd[7:0];
         n_rd = 1; n_wr = 1;
      end else if (mw == 2'b10) begin
         b[h] = wd[7:0]; b[h+1] = wd[15:8];
         n_rd = 1; n_wr = 1;
      end else if (is_ld) begin
         n_rd = 1;
         if (ls == 3'b100) begin
            v = b[lane];
            if (v > 127) v = v - 256;
            ld_val = 32'(v);
         end else if (ls == 3'b101) begin
            v = b[h] + 256 * b[h+1];
            if (v > 32767) v = v - 65536;
            ld_val = 32'(v);
         end else begin
            ld_val = old;
         end
      end
      new_w = {b[3], b[2], b[1], b[0]};
      lat = (n_rd + n_wr == 0) ? 1 : (n_rd + n_wr) * (dly + 1) + 1;
   endtask

   task automatic do_op(input logic [1:0] mw, input logic [2:0] ls, input logic [31:0] a,
                        input logic [31:0] wd, input int dly, input bit pulse, input string tag,
                        output int got);
      logic [31:0] old, exp_w, ld_val;
      logic [AW-1:0] w;
      int n_rd, n_wr, lat, rd0, wr0, us0, busy_bad;
      bit mis, is_ld;
      w   = a[AW+1:2];
      old = tbmem[w];
      model(mw, ls, a, wd, old, dly, exp_w, n_rd, n_wr, lat, mis, is_ld, ld_val);
      if (is_ld) rdata_m = ld_val;
      ack_delay = dly;
      rd0 = rd_cnt; wr0 = wr_cnt; us0 = unstable_cnt;
      mem_write = mw; load_sel = ls; addr = a; wdata = wd; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      mem_write = 2'($urandom); load_sel = 3'($urandom); addr = $urandom; wdata = $urandom;
      got = 0; busy_bad = 0;
      for (int c = 1; c <= 80; c++) begin
         if (busy !== 1'b1) busy_bad++;
         if (done === 1'b1) begin got = c; break; end
         if (pulse) req = (c == 1);
         @(posedge clk); #1;
      end
      req = 1'b0;
      checks++; if (got != lat) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, got, lat); end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL %s busy: low in %0d busy cycles expected 0", tag, busy_bad); end
      checks++; if (rdata !== rdata_m) begin errors++; $display("FAIL %s rdata: got %h expected %h", tag, rdata, rdata_m); end
`ifdef DMEM_MISALIGN_TRAP_EN
      checks++; if (misalign !== mis) begin errors++; $display("FAIL %s misalign: got %b expected %b", tag, misalign, mis); end
`endif
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s idle: done %b busy %b expected 0 0", tag, done, busy); end
      checks++; if (rd_cnt - rd0 != n_rd) begin errors++; $display("FAIL %s reads: got %0d expected %0d", tag, rd_cnt - rd0, n_rd); end
      checks++; if (wr_cnt - wr0 != n_wr) begin errors++; $display("FAIL %s writes: got %0d expected %0d", tag, wr_cnt - wr0, n_wr); end
      checks++; if (tbmem[w] !== exp_w) begin errors++; $display("FAIL %s memword: got %h expected %h", tag, tbmem[w], exp_w); end
      checks++; if (unstable_cnt != us0) begin errors++; $display("FAIL %s stable: %0d changes expected 0", tag, unstable_cnt - us0); end
   endtask

   task automatic test_reset;
      reset = 1'b1; req = 1'b0; mem_write = 2'b00; load_sel = 3'b000; addr = 32'h0; wdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({busy, done, mem_req, mem_we} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, mem_req, mem_we}); end
      checks++; if (mem_addr !== '0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h %h expected 0 0", mem_addr, mem_wdata); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
`ifdef DMEM_MISALIGN_TRAP_EN
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
`endif
      reset = 1'b0;
      rdata_m = 32'h0;
   endtask

   task automatic test_directed;
      int got;
      do_op(2'b11, 3'b000, 32'h10, 32'hDEADBEEF, 0, 1'b0, "sw", got);
      checks++; if (got != 2 || tbmem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_const: lat %0d word %h expected 2 deadbeef", got, tbmem[4]); end
      preload(10'd4, 32'h11223344);
      do_op(2'b01, 3'b000, 32'h12, 32'h000000AB, 0, 1'b0, "sb", got);
      checks++; if (got != 3 || tbmem[4] !== 32'h11AB3344) begin errors++; $display("FAIL sb_const: lat %0d word %h expected 3 11ab3344", got, tbmem[4]); end
      preload(10'd8, 32'h80FF7F01);
      do_op(2'b00, 3'b100, 32'h20, 32'h0, 0, 1'b0, "lb0", got);
      checks++; if (rdata !== 32'h00000001) begin errors++; $display("FAIL lb0_const: got %h expected 00000001", rdata); end
      do_op(2'b00, 3'b100, 32'h22, 32'h0, 0, 1'b0, "lb2", got);
      checks++; if (rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb2_const: got %h expected ffffffff", rdata); end
      do_op(2'b00, 3'b101, 32'h22, 32'h0, 0, 1'b0, "lh2", got);
      checks++; if (rdata !== 32'hFFFF80FF) begin errors++; $display("FAIL lh2_const: got %h expected ffff80ff", rdata); end
      do_op(2'b00, 3'b110, 32'h20, 32'h0, 0, 1'b0, "lw", got);
      checks++; if (rdata !== 32'h80FF7F01) begin errors++; $display("FAIL lw_const: got %h expected 80ff7f01", rdata); end
      do_op(2'b00, 3'b000, 32'h20, 32'h0, 0, 1'b0, "noop", got);
      do_op(2'b00, 3'b110, 32'h13, 32'h0, 0, 1'b0, "lw_mis", got);
`ifdef DMEM_MISALIGN_TRAP_EN
      checks++; if (got != 1 || rdata !== 32'h80FF7F01) begin errors++; $display("FAIL lw_mis_const: lat %0d rdata %h expected 1 80ff7f01", got, rdata); end
`else
      checks++; if (got != 2 || rdata !== 32'h11AB3344) begin errors++; $display("FAIL lw_mis_const: lat %0d rdata %h expected 2 11ab3344", got, rdata); end
`endif
   endtask

   task automatic test_wait_states;
      int got, rd0, wr0;
      preload(10'd6, 32'hCAFEF00D);
      do_op(2'b10, 3'b000, 32'h1A, 32'h12345678, 3, 1'b1, "sh_wait", got);
      checks++; if (got != 9 || tbmem[6] !== 32'h5678F00D) begin errors++; $display("FAIL sh_wait_const: lat %0d word %h expected 9 5678f00d", got, tbmem[6]); end
      rd0 = rd_cnt; wr0 = wr_cnt;
      repeat (4) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0 || rd_cnt != rd0 || wr_cnt != wr0) begin errors++; $display("FAIL req_ignored: busy %b extra rd %0d wr %0d expected 0 0 0", busy, rd_cnt - rd0, wr_cnt - wr0); end
   endtask

   task automatic test_reset_abort;
      int got, wr0;
      preload(10'd5, 32'h0A0B0C0D);
      ack_delay = 6;
      wr0 = wr_cnt;
      mem_write = 2'b01; load_sel = 3'b000; addr = 32'h14; wdata = 32'hEE; req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL abort_read: req %b we %b expected 1 0", mem_req, mem_we); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      rdata_m = 32'h0;
      checks++; if ({busy, done, mem_req, mem_we} !== 4'b0000 || mem_addr !== '0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
         errors++; $display("FAIL abort_clear: ctrl %b addr %h wdata %h rdata %h expected all 0", {busy, done, mem_req, mem_we}, mem_addr, mem_wdata, rdata);
      end
      repeat (8) @(posedge clk);
      #1;
      checks++; if (wr_cnt != wr0 || tbmem[5] !== 32'h0A0B0C0D) begin errors++; $display("FAIL abort_nowrite: writes %0d word %h expected 0 0a0b0c0d", wr_cnt - wr0, tbmem[5]); end
      do_op(2'b00, 3'b110, 32'h14, 32'h0, 0, 1'b0, "lw_after_reset", got);
   endtask

   task automatic test_back_to_back;
      int got;
      do_op(2'b11, 3'b000, 32'h24, 32'h89ABCDEF, 0, 1'b0, "b2b_sw", got);
      do_op(2'b00, 3'b101, 32'h26, 32'h0, 0, 1'b0, "b2b_lh", got);
      do_op(2'b10, 3'b100, 32'h24, 32'h0000FFFF, 0, 1'b0, "b2b_sh", got);
      do_op(2'b00, 3'b110, 32'h24, 32'h0, 1, 1'b0, "b2b_lw", got);
   endtask

   task automatic test_random;
      int got;
      logic [31:0] a;
      for (int i = 0; i < 16; i++) preload(AW'(i), $urandom);
      ack_noise = 1'b1;
      for (int i = 0; i < 60; i++) begin
         a = $urandom;
         a[11:6] = 6'b000000;
         do_op(2'($urandom_range(0, 3)), 3'($urandom), a, $urandom, $urandom_range(0, 2),
               1'($urandom_range(0, 1)), "rand", got);
      end
      ack_noise = 1'b0;
   endtask

   initial begin
      test_reset;
      test_directed;
      test_wait_states;
      test_reset_abort;
      test_back_to_back;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
